// File: rtl/lstm_act_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lstm_act_pkg                                                         |
// | Shared types and helpers for the LSTM activation unit.               |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package lstm_act_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FILL      = 3'd1;
  localparam logic [2:0] ST_FILL_DONE = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_RUN_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_FILL      = ST_FILL,
    S_FILL_DONE = ST_FILL_DONE,
    S_RUN       = ST_RUN,
    S_RUN_DONE  = ST_RUN_DONE
  } state_e;

  typedef enum logic {
    ACT_SIGMOID = 1'b0,
    ACT_TANH    = 1'b1
  } act_mode_e;

  // Fixed-point representation of 1.0 for a given number of fraction bits.
  function automatic int one(input int frac);
    return 1 << frac;
  endfunction

  // Clamp x into the closed range [lo, hi].
  function automatic int sat_int(input int x, input int lo, input int hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lstm_act_pwl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lstm_act_pwl                                                         |
// | Combinational piecewise-linear activation: hard-sigmoid / hard-tanh. |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module lstm_act_pwl
  import lstm_act_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FRAC  = 4
) (
  input  logic signed [WIDTH-1:0] x,
  input  act_mode_e               mode,
  output logic signed [WIDTH-1:0] y
);

  localparam int                    ONE  = one(FRAC);
  localparam logic signed [WIDTH:0] HALF = (WIDTH+1)'(ONE / 2);

  logic signed [WIDTH:0] x_ext;
  logic signed [WIDTH:0] sum;
  int                    y_full;

  // One extra bit of headroom so x/4 + 0.5 can never wrap before clamping.
  always_comb begin
    x_ext  = {x[WIDTH-1], x};
    sum    = (mode == ACT_TANH) ? x_ext : ((x_ext >>> 2) + HALF);
    y_full = (mode == ACT_TANH) ? sat_int(32'(sum), -ONE, ONE)
                                : sat_int(32'(sum), 0, ONE);
    y      = WIDTH'(y_full);
  end

endmodule
`default_nettype wire

// File: rtl/lstm_act_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lstm_act_unit                                                        |
// | Loads DEPTH operands from ROM, applies a run-time selected hard      |
// | activation and streams the results to RAM.                           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module lstm_act_unit
  import lstm_act_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FRAC  = 4,
  parameter int DEPTH = 2,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fill,
  input  logic             req,
  input  logic             mode,
  output logic             ack_fill,
  output logic             ack_network,
  output logic             rom_trig_r,
  output logic [AW-1:0]    rom_abus_r,
  input  logic [WIDTH-1:0] rom_dbus_r,
  output logic             ram_trig_w,
  output logic [AW-1:0]    ram_abus_w,
  output logic [WIDTH-1:0] ram_dbus_w
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e                  state;
  logic                    issue_act;   // address counter is sweeping
  logic [AW-1:0]           cnt;         // address being issued this cycle
  logic                    dly_vld;     // issue_act delayed by one cycle
  logic [AW-1:0]           dly_addr;    // cnt delayed by one cycle
  logic signed [WIDTH-1:0] op_buf [DEPTH];
  logic signed [WIDTH-1:0] pipe_data;
  act_mode_e               mode_q;
  logic signed [WIDTH-1:0] act_y;

  lstm_act_pwl #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_pwl (
    .x    (pipe_data),
    .mode (mode_q),
    .y    (act_y)
  );

  // FSM, address sweep, operand buffer and run pipeline register.
  // The delayed address doubles as the ROM capture index in FILL and as
  // the RAM write index in RUN, since both lag the issued address by one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      issue_act <= 1'b0;
      cnt       <= '0;
      dly_vld   <= 1'b0;
      dly_addr  <= '0;
      pipe_data <= '0;
      mode_q    <= ACT_SIGMOID;
      for (int k = 0; k < DEPTH; k++) op_buf[k] <= '0;
    end else begin
      dly_vld  <= issue_act;
      dly_addr <= cnt;
      if (issue_act) begin
        if (cnt == LAST) issue_act <= 1'b0;
        else             cnt       <= cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (fill) begin
            state     <= S_FILL;
            issue_act <= 1'b1;
            cnt       <= '0;
          end else if (req) begin
            state     <= S_RUN;
            issue_act <= 1'b1;
            cnt       <= '0;
            mode_q    <= act_mode_e'(mode);
          end
        end
        S_FILL: begin
          if (dly_vld) begin
            op_buf[dly_addr] <= rom_dbus_r;
            if (dly_addr == LAST) state <= fill ? S_FILL_DONE : S_IDLE;
          end
        end
        S_FILL_DONE: begin
          if (!fill) state <= S_IDLE;
        end
        S_RUN: begin
          if (issue_act) pipe_data <= op_buf[cnt];
          if (dly_vld && (dly_addr == LAST)) state <= req ? S_RUN_DONE : S_IDLE;
        end
        S_RUN_DONE: begin
          if (!req) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from registered state and forced to zero when idle.
  assign rom_trig_r  = issue_act && (state == S_FILL);
  assign rom_abus_r  = rom_trig_r ? cnt : '0;
  assign ram_trig_w  = dly_vld && (state == S_RUN);
  assign ram_abus_w  = ram_trig_w ? dly_addr : '0;
  assign ram_dbus_w  = ram_trig_w ? act_y : '0;
  assign ack_fill    = (state == S_FILL_DONE);
  assign ack_network = (state == S_RUN_DONE);

endmodule
`default_nettype wire

// File: tb/tb_lstm_act_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lstm_act_unit                                                     |
// | Self-checking bench: two instances (DEPTH=2 and DEPTH=5) with ROM    |
// | models, checked against a real-arithmetic activation model.          |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_lstm_act_unit;

  localparam int W = 8, FRAC = 4, ONE = 16, D0 = 2, D1 = 5, AW0 = 1, AW1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [1:0] fill_v = '0, req_v = '0, mode_v = '0;

  logic           ack_fill0, ack_net0, rom_trig0, ram_trig0;
  logic [AW0-1:0] rom_abus0, ram_abus0;
  logic [W-1:0]   rom_dbus0 = '0, ram_dbus0;
  logic           ack_fill1, ack_net1, rom_trig1, ram_trig1;
  logic [AW1-1:0] rom_abus1, ram_abus1;
  logic [W-1:0]   rom_dbus1 = '0, ram_dbus1;

  lstm_act_unit #(.WIDTH(W), .FRAC(FRAC), .DEPTH(D0)) dut0 (
    .clk(clk), .rst(rst), .fill(fill_v[0]), .req(req_v[0]), .mode(mode_v[0]),
    .ack_fill(ack_fill0), .ack_network(ack_net0),
    .rom_trig_r(rom_trig0), .rom_abus_r(rom_abus0), .rom_dbus_r(rom_dbus0),
    .ram_trig_w(ram_trig0), .ram_abus_w(ram_abus0), .ram_dbus_w(ram_dbus0));

  lstm_act_unit #(.WIDTH(W), .FRAC(FRAC), .DEPTH(D1)) dut1 (
    .clk(clk), .rst(rst), .fill(fill_v[1]), .req(req_v[1]), .mode(mode_v[1]),
    .ack_fill(ack_fill1), .ack_network(ack_net1),
    .rom_trig_r(rom_trig1), .rom_abus_r(rom_abus1), .rom_dbus_r(rom_dbus1),
    .ram_trig_w(ram_trig1), .ram_abus_w(ram_abus1), .ram_dbus_w(ram_dbus1));

  int rom_img [2][5];
  int exp_buf [2][5];
  int errors = 0, checks = 0;

  // ROM models: data for a strobed address appears one cycle later.
  always @(posedge clk) if (rom_trig0) rom_dbus0 <= W'(rom_img[0][rom_abus0]);
  always @(posedge clk) if (rom_trig1) rom_dbus1 <= W'(rom_img[1][rom_abus1]);

  logic s_rom_trig [2], s_ram_trig [2], s_ackf [2], s_ackn [2];
  int   s_rom_addr [2], s_ram_addr [2], s_ram_data [2];
  assign s_rom_trig[0] = rom_trig0;  assign s_rom_trig[1] = rom_trig1;
  assign s_ram_trig[0] = ram_trig0;  assign s_ram_trig[1] = ram_trig1;
  assign s_ackf[0] = ack_fill0;      assign s_ackf[1] = ack_fill1;
  assign s_ackn[0] = ack_net0;       assign s_ackn[1] = ack_net1;
  assign s_rom_addr[0] = 32'(rom_abus0);  assign s_rom_addr[1] = 32'(rom_abus1);
  assign s_ram_addr[0] = 32'(ram_abus0);  assign s_ram_addr[1] = 32'(ram_abus1);
  assign s_ram_data[0] = 32'(signed'(ram_dbus0));
  assign s_ram_data[1] = 32'(signed'(ram_dbus1));

  function automatic int dep(input int u);
    return (u != 0) ? D1 : D0;
  endfunction

  // Reference activation from the real-valued definitions.
  function automatic int ref_act(input int x, input bit md);
    int y, lo;
    if (md) begin y = x; lo = -ONE; end
    else begin y = int'($floor(x / 4.0)) + ONE / 2; lo = 0; end
    if (y < lo) y = lo;
    if (y > ONE) y = ONE;
    return y;
  endfunction

  task automatic run_fill(input int u, output int ack_at, output int strobes,
                          output bit order_ok, output bit ack_drop);
    @(negedge clk); fill_v[u] = 1'b1;
    @(posedge clk);
    ack_at = -1; strobes = 0; order_ok = 1'b1;
    for (int k = 1; k <= 40 && ack_at < 0; k++) begin
      @(negedge clk);
      if (s_rom_trig[u]) begin
        if (s_rom_addr[u] != k - 1 || k > dep(u)) order_ok = 1'b0;
        strobes++;
      end
      if (s_ackf[u]) ack_at = k;
    end
    fill_v[u] = 1'b0;
    @(negedge clk); ack_drop = s_ackf[u];
    for (int i = 0; i < 5; i++) exp_buf[u][i] = (i < dep(u)) ? rom_img[u][i] : 0;
  endtask

  task automatic run_req(input int u, input bit md, input bit toggle, output int ack_at,
                         output int writes, output bit order_ok, output bit ack_drop,
                         output int got [5]);
    for (int i = 0; i < 5; i++) got[i] = -999;
    @(negedge clk); req_v[u] = 1'b1; mode_v[u] = md;
    @(posedge clk);
    ack_at = -1; writes = 0; order_ok = 1'b1;
    for (int k = 1; k <= 40 && ack_at < 0; k++) begin
      @(negedge clk);
      if (toggle && k == 1) mode_v[u] = ~md;
      if (s_ram_trig[u]) begin
        if (s_ram_addr[u] != k - 2 || k < 2 || k > dep(u) + 1) order_ok = 1'b0;
        if (s_ram_addr[u] < 5) got[s_ram_addr[u]] = s_ram_data[u];
        writes++;
      end
      if (s_ackn[u]) ack_at = k;
    end
    req_v[u] = 1'b0;
    @(negedge clk); ack_drop = s_ackn[u];
    mode_v[u] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({s_ackf[u], s_ackn[u], s_rom_trig[u], s_ram_trig[u]} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_flags u%0d: got %b%b%b%b expected 0000", u,
                 s_ackf[u], s_ackn[u], s_rom_trig[u], s_ram_trig[u]);
      end
      checks++;
      if (s_rom_addr[u] != 0 || s_ram_addr[u] != 0 || s_ram_data[u] != 0) begin
        errors++;
        $display("FAIL reset_buses u%0d: got %0d/%0d/%0d expected 0/0/0", u,
                 s_rom_addr[u], s_ram_addr[u], s_ram_data[u]);
      end
    end
    rst = 1'b0;
    for (int u = 0; u < 2; u++) for (int i = 0; i < 5; i++) exp_buf[u][i] = 0;
  endtask

  task automatic test_no_fill();
    int ack_at, writes, got [5];
    bit ok, drop;
    run_req(0, 1'b0, 1'b0, ack_at, writes, ok, drop, got);
    for (int i = 0; i < D0; i++) begin
      checks++;
      if (got[i] != 8) begin errors++; $display("FAIL nofill_val[%0d]: got %0d expected 8", i, got[i]); end
    end
    checks++;
    if (writes != D0 || !ok) begin
      errors++; $display("FAIL nofill_writes: got %0d ordered=%0b expected %0d ordered=1", writes, ok, D0);
    end
  endtask

  task automatic test_defaults();
    int ack_at, n, got [5];
    bit ok, drop;
    int vals [4][2] = '{'{16, 16}, '{16, 16}, '{-128, 127}, '{-128, 127}};
    bit mds [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int exps [4][2] = '{'{12, 12}, '{16, 16}, '{-16, 16}, '{0, 16}};
    for (int t = 0; t < 4; t++) begin
      if (t == 0 || t == 2) begin
        rom_img[0][0] = vals[t][0]; rom_img[0][1] = vals[t][1];
        run_fill(0, ack_at, n, ok, drop);
        checks++;
        if (ack_at != D0 + 2 || n != D0 || !ok || drop) begin
          errors++;
          $display("FAIL fill_timing t%0d: ack_at=%0d strobes=%0d ordered=%0b drop=%0b expected %0d/%0d/1/0",
                   t, ack_at, n, ok, drop, D0 + 2, D0);
        end
      end
      run_req(0, mds[t], 1'b0, ack_at, n, ok, drop, got);
      checks++;
      if (ack_at != D0 + 2 || n != D0 || !ok || drop) begin
        errors++;
        $display("FAIL run_timing t%0d: ack_at=%0d writes=%0d ordered=%0b drop=%0b expected %0d/%0d/1/0",
                 t, ack_at, n, ok, drop, D0 + 2, D0);
      end
      for (int i = 0; i < D0; i++) begin
        checks++;
        if (got[i] != exps[t][i]) begin
          errors++; $display("FAIL default_val t%0d[%0d]: got %0d expected %0d", t, i, got[i], exps[t][i]);
        end
      end
    end
  endtask

  task automatic test_depth5();
    int ack_at, n, got [5];
    bit ok, drop;
    int vals [5] = '{0, -8, 8, -32, 32};
    int exps [5] = '{8, 6, 10, 0, 16};
    for (int i = 0; i < 5; i++) rom_img[1][i] = vals[i];
    run_fill(1, ack_at, n, ok, drop);
    checks++;
    if (ack_at != D1 + 2 || n != D1 || !ok) begin
      errors++; $display("FAIL d5_fill: ack_at=%0d strobes=%0d ordered=%0b expected %0d/%0d/1", ack_at, n, ok, D1 + 2, D1);
    end
    run_req(1, 1'b0, 1'b0, ack_at, n, ok, drop, got);
    checks++;
    if (ack_at != D1 + 2 || n != D1 || !ok) begin
      errors++; $display("FAIL d5_run: ack_at=%0d writes=%0d ordered=%0b expected %0d/%0d/1", ack_at, n, ok, D1 + 2, D1);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got[i] != exps[i]) begin errors++; $display("FAIL d5_val[%0d]: got %0d expected %0d", i, got[i], exps[i]); end
    end
  endtask

  task automatic test_priority();
    int ack_at = -1, n = 0, got [5];
    bit saw_ram = 1'b0, held_bad = 1'b0, md;
    md = 1'($urandom_range(0, 1));
    for (int i = 0; i < 5; i++) got[i] = -999;
    rom_img[0][0] = $urandom_range(0, 255) - 128; rom_img[0][1] = $urandom_range(0, 255) - 128;
    @(negedge clk); fill_v[0] = 1'b1; req_v[0] = 1'b1; mode_v[0] = md;
    @(posedge clk);
    for (int k = 1; k <= 30 && ack_at < 0; k++) begin
      @(negedge clk);
      if (s_ram_trig[0]) saw_ram = 1'b1;
      if (s_ackf[0]) ack_at = k;
    end
    repeat (3) begin
      @(negedge clk);
      if (s_ram_trig[0] || !s_ackf[0]) held_bad = 1'b1;
    end
    checks++;
    if (ack_at != D0 + 2 || saw_ram || held_bad) begin
      errors++; $display("FAIL prio_fill_first: ack_at=%0d ram_seen=%0b held_bad=%0b expected %0d/0/0",
                         ack_at, saw_ram, held_bad, D0 + 2);
    end
    for (int i = 0; i < D0; i++) exp_buf[0][i] = rom_img[0][i];
    fill_v[0] = 1'b0;
    ack_at = -1;
    for (int k = 1; k <= 30 && ack_at < 0; k++) begin
      @(negedge clk);
      if (s_ram_trig[0]) begin got[s_ram_addr[0]] = s_ram_data[0]; n++; end
      if (s_ackn[0]) ack_at = k;
    end
    req_v[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (ack_at < 0 || n != D0) begin
      errors++; $display("FAIL prio_run_after: ack_at=%0d writes=%0d expected ack and %0d writes", ack_at, n, D0);
    end
    for (int i = 0; i < D0; i++) begin
      checks++;
      if (got[i] != ref_act(exp_buf[0][i], md)) begin
        errors++; $display("FAIL prio_val[%0d]: got %0d expected %0d", i, got[i], ref_act(exp_buf[0][i], md));
      end
    end
  endtask

  task automatic test_drop_midrun();
    int n = 0, got [5];
    bit saw_ack = 1'b0;
    for (int i = 0; i < 5; i++) got[i] = -999;
    @(negedge clk); req_v[1] = 1'b1; mode_v[1] = 1'b1;
    @(posedge clk);
    @(negedge clk); req_v[1] = 1'b0;
    repeat (14) begin
      if (s_ram_trig[1]) begin if (s_ram_addr[1] < 5) got[s_ram_addr[1]] = s_ram_data[1]; n++; end
      if (s_ackn[1]) saw_ack = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (n != D1 || saw_ack) begin
      errors++; $display("FAIL drop_midrun: writes=%0d ack_seen=%0b expected %0d/0", n, saw_ack, D1);
    end
    for (int i = 0; i < D1; i++) begin
      checks++;
      if (got[i] != ref_act(exp_buf[1][i], 1'b1)) begin
        errors++; $display("FAIL drop_val[%0d]: got %0d expected %0d", i, got[i], ref_act(exp_buf[1][i], 1'b1));
      end
    end
    mode_v[1] = 1'b0;
  endtask

  task automatic test_rst_midrun();
    int ack_at, n, got [5];
    bit ok, drop;
    @(negedge clk); req_v[0] = 1'b1; mode_v[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_ackf[0], s_ackn[0], s_rom_trig[0], s_ram_trig[0]} !== 4'b0000 ||
        s_ram_addr[0] != 0 || s_ram_data[0] != 0 || s_rom_addr[0] != 0) begin
      errors++; $display("FAIL rst_midrun_outputs: ram_trig=%0b data=%0d ack=%0b expected all 0",
                         s_ram_trig[0], s_ram_data[0], s_ackn[0]);
    end
    rst = 1'b0; req_v[0] = 1'b0;
    for (int u = 0; u < 2; u++) for (int i = 0; i < 5; i++) exp_buf[u][i] = 0;
    @(negedge clk);
    checks++;
    if (s_ram_trig[0] !== 1'b0 || s_rom_trig[0] !== 1'b0) begin
      errors++; $display("FAIL rst_idle: ram_trig=%0b rom_trig=%0b expected 0/0", s_ram_trig[0], s_rom_trig[0]);
    end
    rom_img[0][0] = $urandom_range(0, 255) - 128; rom_img[0][1] = $urandom_range(0, 255) - 128;
    run_fill(0, ack_at, n, ok, drop);
    run_req(0, 1'b1, 1'b0, ack_at, n, ok, drop, got);
    checks++;
    if (ack_at != D0 + 2 || n != D0) begin
      errors++; $display("FAIL rst_recover_run: ack_at=%0d writes=%0d expected %0d/%0d", ack_at, n, D0 + 2, D0);
    end
    for (int i = 0; i < D0; i++) begin
      checks++;
      if (got[i] != ref_act(exp_buf[0][i], 1'b1)) begin
        errors++; $display("FAIL rst_recover_val[%0d]: got %0d expected %0d", i, got[i], ref_act(exp_buf[0][i], 1'b1));
      end
    end
  endtask

  task automatic test_random();
    int ack_at, n, got [5], u;
    bit ok, drop, md, tg;
    for (int it = 0; it < 8; it++) begin
      u = it % 2;
      md = 1'($urandom_range(0, 1));
      tg = 1'($urandom_range(0, 1));
      for (int i = 0; i < 5; i++) rom_img[u][i] = $urandom_range(0, 255) - 128;
      run_fill(u, ack_at, n, ok, drop);
      checks++;
      if (ack_at != dep(u) + 2 || n != dep(u) || !ok || drop) begin
        errors++; $display("FAIL rand_fill it%0d: ack_at=%0d strobes=%0d ordered=%0b drop=%0b", it, ack_at, n, ok, drop);
      end
      run_req(u, md, tg, ack_at, n, ok, drop, got);
      checks++;
      if (ack_at != dep(u) + 2 || n != dep(u) || !ok || drop) begin
        errors++; $display("FAIL rand_run it%0d: ack_at=%0d writes=%0d ordered=%0b drop=%0b", it, ack_at, n, ok, drop);
      end
      for (int i = 0; i < dep(u); i++) begin
        checks++;
        if (got[i] != ref_act(exp_buf[u][i], md)) begin
          errors++; $display("FAIL rand_val it%0d[%0d]: x=%0d mode=%0b toggled=%0b got %0d expected %0d",
                             it, i, exp_buf[u][i], md, tg, got[i], ref_act(exp_buf[u][i], md));
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_no_fill();
    test_defaults();
    test_depth5();
    test_priority();
    test_drop_midrun();
    test_rst_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lstm_act_unit.md
# lstm_act_unit

Parametrised fixed-point activation unit for the LSTM datapath; successor of the fixed sigmoid/tanh network pair. It loads DEPTH signed operands from an input ROM during a fill phase, then on request applies a run-time-selected activation (hard-sigmoid or hard-tanh, piecewise-linear) and writes the results to an output RAM. One instance serves all LSTM gates, replacing separate per-function networks.

## Interface
- WIDTH, 8: operand/result width, signed two's complement
- FRAC, 4: fractional bits; ONE = 1<<FRAC (16 = 1.0 at defaults)
- DEPTH, 2: number of elements per fill/run; ≥1
- AW, max(1,$clog2(DEPTH)): address width (derived)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- fill  in  1  level request to load operands from ROM
- req  in  1  level request to compute and store results
- mode  in  1  0 = hard-sigmoid, 1 = hard-tanh; sampled on entry to RUN
- ack_fill  out  1  fill complete, held while fill stays high
- ack_network  out  1  run complete, held while req stays high
- rom_trig_r  out  1  ROM read strobe
- rom_abus_r  out  AW  ROM read address
- rom_dbus_r  in  WIDTH  ROM data, valid one clk cycle after address/strobe
- ram_trig_w  out  1  RAM write strobe
- ram_abus_w  out  AW  RAM write address
- ram_dbus_w  out  WIDTH  RAM write data

## Operation
- States: IDLE, FILL, FILL_DONE, RUN, RUN_DONE.
- IDLE: fill=1 -> FILL (fill has priority if fill and req both high); else req=1 -> RUN.
- FILL: counter i = 0..DEPTH-1 drives rom_abus_r=i, rom_trig_r=1 for DEPTH cycles; rom_dbus_r captured into buf[i] the cycle after address i. After last capture -> FILL_DONE.
- FILL_DONE: ack_fill=1; fill=0 -> IDLE.
- RUN: mode latched on entry. Counter j reads buf[j] into a one-stage pipeline register; next cycle writes f(buf[j]) with ram_trig_w=1, ram_abus_w=j. After write of DEPTH-1 -> RUN_DONE.
- RUN_DONE: ack_network=1; req=0 -> IDLE.
- Hard-sigmoid: y = sat(x>>>2 + ONE/2, 0, ONE). Hard-tanh: y = sat(x, -ONE, ONE). Internal sum computed at WIDTH+1 bits, then saturated; never wraps.
- req while buffer never filled: computes on zeros (reset buffer contents).
- fill/req deassert mid-phase: ignored; phase runs to completion, ack then asserts only if the request is still high, else direct return to IDLE.
- mode changes mid-RUN: ignored until next RUN.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, buf cleared, mode latch 0.
- rst mid-operation: next cycle IDLE, strobes and acks low; partial RAM writes not retracted.
- Fill latency: fill sampled at edge 0; ROM strobes edges 1..DEPTH; captures edges 2..DEPTH+1; ack_fill high from edge DEPTH+2.
- Run latency: req sampled at edge 0; writes in cycles 2..DEPTH+1; ack_network high from edge DEPTH+2.
- Exactly DEPTH strobes per phase; strobes never high outside FILL/RUN.
- Acks drop the cycle after the corresponding request drops.

## Structure
- Package lstm_act_pkg: state enum, mode enum (ACT_SIGMOID, ACT_TANH), function one(FRAC), saturating helper.
- Sub-module lstm_act_pwl: combinational (x, mode) -> y activation, parametrised WIDTH/FRAC; top holds FSM, counters, buffer, pipeline register.

## Test plan
- Defaults, ROM {16,16}, fill then req mode=0 -> RAM {12,12}; ack_fill at edge 4, ack_network at edge 4 of run.
- Same ROM, mode=1 -> RAM {16,16}; ROM {-128,127} mode=1 -> {-16,16}; mode=0 -> {0,16} (saturation both ends).
- DEPTH=5, ROM {0,-8,8,-32,32}, mode=0 -> {8,6,10,0,16}; exactly 5 strobes per phase, addresses 0..4 in order.
- fill and req both high in IDLE -> FILL first; RUN only after fill drops and req still high.
- rst asserted at RUN cycle 2 -> all outputs 0 next cycle, IDLE; subsequent fill/req completes normally.
- req without prior fill, mode=0 -> RAM all 8; mode toggled mid-RUN -> results use entry mode.
